// File: rtl/program_loader_pkg.sv
// Shared loader definitions: FSM encoding, frame geometry and the instruction width used by the core.
// Defining PROGRAM_LOADER_CHECKSUM_EN adds the trailing XOR CHECK state.
package program_loader_pkg;

  localparam int unsigned LOADER_WORD_BYTES  = 4;
  localparam int unsigned LOADER_LEN_BYTES   = 2;
  localparam int unsigned LOADER_INSTR_WIDTH = 28;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
    ST_WRITE,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    ST_CHECK,
`endif
    ST_DONE,
    ST_ERR
  } loader_state_t;

endpackage

// File: rtl/byte_assembler.sv
// MSB-first 32-bit instruction assembler with a 2-bit byte index; last_byte flags that the
// next shifted byte completes the word.
module byte_assembler
  import program_loader_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           shift,
  input  logic                           clear,
  input  logic [7:0]                     data,
  output logic [LOADER_WORD_BYTES*8-1:0] word,
  output logic                           last_byte
);

  logic [1:0] idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word <= '0;
      idx  <= '0;
    end else if (clear) begin
      word <= '0;
      idx  <= '0;
    end else if (shift) begin
      word <= {word[LOADER_WORD_BYTES*8-9:0], data};
      idx  <= idx + 2'd1;
    end
  end

  assign last_byte = (idx == 2'(LOADER_WORD_BYTES - 1));

endmodule

// File: rtl/program_loader.sv
// Framed byte-stream loader for the MiniAlu instruction memory; holds the core in reset until
// the image is loaded. Optional trailing checksum: PROGRAM_LOADER_CHECKSUM_EN.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int INSTR_WIDTH = LOADER_INSTR_WIDTH
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   iStart,
  input  logic [7:0]             iByte,
  input  logic                   iByteValid,
  output logic                   oByteReady,
  output logic                   oWriteEnable,
  output logic [ADDR_WIDTH-1:0]  oWriteAddress,
  output logic [INSTR_WIDTH-1:0] oWriteData,
  output logic                   oCpuReset,
  output logic                   oDone,
  output logic                   oError,
  output logic [15:0]            oWordCount
);

  localparam int unsigned CAPACITY = 1 << ADDR_WIDTH;

  loader_state_t                  state;
  logic [ADDR_WIDTH-1:0]          word_idx;
  logic                           first_byte;
  logic                           take;
  logic                           start_ok;
  logic                           last_word;
  logic [15:0]                    len_next;
  logic [LOADER_WORD_BYTES*8-1:0] asm_word;
  logic                           asm_last;
  logic                           unused_top_nibble;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]                     csum;
`endif

  assign take      = iByteValid & oByteReady;
  assign start_ok  = iStart && (state == ST_IDLE || state == ST_DONE || state == ST_ERR);
  assign len_next  = {oWordCount[15:8], iByte};
  assign last_word = (32'(word_idx) + 32'd1 == 32'(oWordCount));

  byte_assembler u_asm (
    .clk       (Clock),
    .rst_n     (Reset),
    .shift     (take && state == ST_DATA),
    .clear     (start_ok || state == ST_WRITE),
    .data      (iByte),
    .word      (asm_word),
    .last_byte (asm_last)
  );

  // Address and data come straight from registers that are stable throughout WRITE.
  assign oWriteAddress     = word_idx;
  assign oWriteData        = asm_word[INSTR_WIDTH-1:0];
  assign unused_top_nibble = ^asm_word[LOADER_WORD_BYTES*8-1:INSTR_WIDTH];

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state        <= ST_IDLE;
      oByteReady   <= 1'b0;
      oWriteEnable <= 1'b0;
      oCpuReset    <= 1'b1;
      oDone        <= 1'b0;
      oError       <= 1'b0;
      oWordCount   <= '0;
      word_idx     <= '0;
      first_byte   <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum         <= '0;
`endif
    end else begin
      oWriteEnable <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (iStart) begin
            state      <= ST_LEN_HI;
            oByteReady <= 1'b1;
            oDone      <= 1'b0;
            oError     <= 1'b0;
            oCpuReset  <= 1'b1;
            word_idx   <= '0;
          end
        end
        ST_LEN_HI: begin
          if (take) begin
            oWordCount[15:8] <= iByte;
            state            <= ST_LEN_LO;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum             <= iByte;
`endif
          end
        end
        ST_LEN_LO: begin
          if (take) begin
            oWordCount[7:0] <= iByte;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum            <= csum ^ iByte;
`endif
            if (32'(len_next) > CAPACITY) begin
              state      <= ST_ERR;
              oByteReady <= 1'b0;
              oError     <= 1'b1;
            end else if (len_next == 16'd0) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
              state      <= ST_CHECK;
`else
              state      <= ST_DONE;
              oByteReady <= 1'b0;
              oDone      <= 1'b1;
              oCpuReset  <= 1'b0;
`endif
            end else begin
              state      <= ST_DATA;
              first_byte <= 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (take) begin
            first_byte <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum       <= csum ^ iByte;
`endif
            if (first_byte && iByte[7:4] != 4'd0) begin
              state      <= ST_ERR;
              oByteReady <= 1'b0;
              oError     <= 1'b1;
            end else if (asm_last) begin
              state        <= ST_WRITE;
              oByteReady   <= 1'b0;
              oWriteEnable <= 1'b1;
            end
          end
        end
        ST_WRITE: begin
          if (last_word) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            state      <= ST_CHECK;
            oByteReady <= 1'b1;
`else
            state     <= ST_DONE;
            oDone     <= 1'b1;
            oCpuReset <= 1'b0;
`endif
          end else begin
            word_idx   <= word_idx + 1'b1;
            state      <= ST_DATA;
            oByteReady <= 1'b1;
            first_byte <= 1'b1;
          end
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (take) begin
            oByteReady <= 1'b0;
            if (iByte == csum) begin
              state     <= ST_DONE;
              oDone     <= 1'b1;
              oCpuReset <= 1'b0;
            end else begin
              state  <= ST_ERR;
              oError <= 1'b1;
            end
          end
        end
`endif
        default: begin
          state      <= ST_IDLE;
          oByteReady <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected writes are queued as stimulus is issued and a
// negedge monitor pops and compares every write strobe.
module tb_program_loader;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_ready;
  logic        write_en;
  logic [7:0]  write_addr;
  logic [27:0] write_data;
  logic        cpu_reset;
  logic        done;
  logic        error;
  logic [15:0] word_count;

  int checks   = 0;
  int failures = 0;
  int write_count = 0;
  logic [7:0]  last_addr = '0;
  logic [35:0] exp_q[$];
  logic [31:0] img[$];
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  bit corrupt_sum = 1'b0;
`endif

  program_loader #(.ADDR_WIDTH(8), .INSTR_WIDTH(28)) dut (
    .Clock        (clock),
    .Reset        (reset_n),
    .iStart       (start),
    .iByte        (byte_data),
    .iByteValid   (byte_valid),
    .oByteReady   (byte_ready),
    .oWriteEnable (write_en),
    .oWriteAddress(write_addr),
    .oWriteData   (write_data),
    .oCpuReset    (cpu_reset),
    .oDone        (done),
    .oError       (error),
    .oWordCount   (word_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset_n && write_en) begin
      logic [35:0] e;
      write_count++;
      last_addr = write_addr;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write actual=%h/%h required=none", write_addr, write_data);
      end else begin
        e = exp_q.pop_front();
        if (write_addr !== e[35:28] || write_data !== e[27:0]) begin
          failures++;
          $display("FAIL write actual=%h/%h required=%h/%h", write_addr, write_data, e[35:28], e[27:0]);
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge following the accepting posedge.
  task automatic send_byte(input logic [7:0] b, input bit stall);
    int n = 0;
    if (stall) repeat ($urandom_range(0, 3)) @(negedge clock);
    byte_data  = b;
    byte_valid = 1'b1;
    while (!byte_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (n >= 20) begin
      checks++;
      failures++;
      $display("FAIL byte_accept_timeout actual=ready0 required=ready1 byte=%h", b);
    end
    @(negedge clock);
    byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic do_load(input logic [15:0] n, input int nwords, input bit stall);
    logic [7:0]  x;
    logic [31:0] w;
    x = n[15:8] ^ n[7:0];
    send_byte(n[15:8], stall);
    send_byte(n[7:0], stall);
    for (int i = 0; i < nwords; i++) begin
      w = img[i];
      exp_q.push_back({8'(i), w[27:0]});
      for (int k = 3; k >= 0; k--) begin
        send_byte(w[8*k +: 8], stall);
        x = x ^ w[8*k +: 8];
      end
    end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_byte(corrupt_sum ? ~x : x, stall);
`endif
  endtask

  task automatic set_basic();
    img.delete();
    img.push_back(32'h0123_4567);
    img.push_back(32'h0ABC_DEF0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, byte_ready, 0);
    check({tag, "_we"},    write_en,   0);
    check({tag, "_addr"},  write_addr, 0);
    check({tag, "_data"},  write_data, 0);
    check({tag, "_cpu"},   cpu_reset,  1);
    check({tag, "_done"},  done,       0);
    check({tag, "_err"},   error,      0);
    check({tag, "_count"}, word_count, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    reset_n = 1'b0; start = 1'b0; byte_data = '0; byte_valid = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_values("reset");
    reset_n = 1'b1;
    @(negedge clock);
    check("idle_ready", byte_ready, 0);

    // Basic two-word load
    set_basic();
    w0 = write_count;
    pulse_start();
    do_load(16'd2, 2, 1'b0);
    @(negedge clock); #1;
    check("basic_done", done, 1);
    check("basic_cpu", cpu_reset, 0);
    check("basic_err", error, 0);
    check("basic_count", word_count, 2);
    check("basic_writes", write_count - w0, 2);

    // Empty image
    w0 = write_count;
    pulse_start();
    check("restart_done_cleared", done, 0);
    check("restart_cpu", cpu_reset, 1);
    do_load(16'd0, 0, 1'b0);
    @(negedge clock); #1;
    check("empty_done", done, 1);
    check("empty_writes", write_count - w0, 0);

    // Format error on first data byte, then clean reload
    w0 = write_count;
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h1F, 1'b0);
    #1;
    check("fmt_err", error, 1);
    check("fmt_cpu", cpu_reset, 1);
    check("fmt_done", done, 0);
    check("fmt_ready", byte_ready, 0);
    check("fmt_writes", write_count - w0, 0);
    @(negedge clock);
    pulse_start();
    check("fmt_err_cleared", error, 0);
    do_load(16'd2, 2, 1'b0);
    @(negedge clock); #1;
    check("reload_done", done, 1);
    check("reload_writes", write_count - w0, 2);

    // Capacity: 300 words rejected, 256 words fill the memory exactly
    w0 = write_count;
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h2C, 1'b0);
    #1;
    check("cap_err", error, 1);
    check("cap_writes", write_count - w0, 0);
    @(negedge clock);
    img.delete();
    for (int i = 0; i < 256; i++) img.push_back({4'h0, 8'(i), 8'(~i), 12'(i * 3)});
    pulse_start();
    do_load(16'd256, 256, 1'b0);
    @(negedge clock); #1;
    check("full_done", done, 1);
    check("full_last_addr", last_addr, 8'hFF);
    check("full_writes", write_count - w0, 256);

    // Random valid gaps must not change the result
    set_basic();
    w0 = write_count;
    pulse_start();
    do_load(16'd2, 2, 1'b1);
    @(negedge clock); #1;
    check("stall_done", done, 1);
    check("stall_writes", write_count - w0, 2);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    // Wrong trailing checksum
    w0 = write_count;
    corrupt_sum = 1'b1;
    pulse_start();
    do_load(16'd2, 2, 1'b0);
    corrupt_sum = 1'b0;
    @(negedge clock); #1;
    check("sum_err", error, 1);
    check("sum_done", done, 0);
    check("sum_writes", write_count - w0, 2);
`endif

    // Reset pulled after the 5th byte
    w0 = write_count;
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h23, 1'b0);
    send_byte(8'h45, 1'b0);
    reset_n = 1'b0;
    #1;
    check_reset_values("midrst");
    @(negedge clock);
    reset_n = 1'b1;
    byte_data = 8'h67;
    byte_valid = 1'b1;
    repeat (10) @(negedge clock);
    byte_valid = 1'b0;
    #1;
    check("midrst_writes", write_count - w0, 0);
    check("midrst_ready", byte_ready, 0);
    check("midrst_cpu_held", cpu_reset, 1);

    check("pending_writes", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
